serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk_in  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_in  input  1  request to begin an addition; sampled on the rising edge.
REQ-005 SHALL have port a_in  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL have port b_in  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL have port c_in  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy_out  output  1  high while bits are being computed.
REQ-009 SHALL have port done_out  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port sum_out  output  WIDTH  registered sum.
REQ-011 SHALL have port carry_out  output  1  registered final carry.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept start_in only in IDLE or DONE.
- On acceptance: latch a_in, b_in, c_in into shift/carry registers.
- Clear the bit counter.
- Go to RUN.
REQ-014 SHALL ignore start_in in RUN, with no effect on operands, counter or outputs.
REQ-015 SHALL, on each RUN cycle, use a 1-bit full add of the A LSB, the B LSB and the carry register, then:
- shift the sum bit into the result register from the MSB side;
- shift A and B right by one;
- update the carry register;
- increment the counter.
REQ-016 SHALL process bits LSB first, exactly WIDTH RUN cycles per operation.
REQ-017 SHALL transition RUN->DONE on the edge that computes bit WIDTH-1.
REQ-018 SHALL drive busy_out high only in RUN.
- busy_out rises on the edge after start is sampled.
- busy_out falls WIDTH edges later.
REQ-019 SHALL drive done_out high only in DONE, for exactly one cycle.
REQ-020 SHALL transition DONE->IDLE unconditionally, or DONE->RUN if start_in is high (back-to-back operation).
REQ-021 SHALL hold sum_out and carry_out constant from entry to DONE until the next accepted start.
REQ-022 SHALL keep sum_out and carry_out unchanged while in RUN; the result register is internal until DONE.
REQ-023 SHALL produce {carry_out, sum_out} = a_in + b_in + c_in, computed modulo 2^(WIDTH+1).

Reset
REQ-024 SHALL, when rst_in is high at a rising edge, force:
- state IDLE;
- busy_out=0, done_out=0, sum_out=0, carry_out=0;
- counter=0, carry register=0.
REQ-025 SHALL, on reset during RUN, abort the operation with no done_out pulse; the first start after reset SHALL be accepted normally.
REQ-026 SHALL give rst_in priority over start_in in the same cycle.

Structure
REQ-027 SHALL place the FSM state encoding and the counter-width constant ($clog2(WIDTH)+1) in shared package serial_adder_pkg.
REQ-028 SHALL instantiate exactly one sub-module, fa_cell, a combinational 1-bit full adder (a, b, cin -> sum, cout).
REQ-029 SHALL contain no other arithmetic wider than the counter increment.

Verification (WIDTH=8)
REQ-030 SHALL cover: a=0x5A, b=0x3C, c=0, one start pulse.
- busy_out high 8 cycles.
- done_out pulses on the 9th edge after start; sum_out=0x96, carry_out=0.
REQ-031 SHALL cover: a=0xFF, b=0x01, c=0.
- sum_out=0x00, carry_out=1.
REQ-032 SHALL cover: a=0xFF, b=0xFF, c=1.
- sum_out=0xFF, carry_out=1.
REQ-033 SHALL cover: start with a=0x01, b=0x01, then start_in held high with a=0xAA, b=0x55 during RUN.
- First result 0x02/0, unaffected.
- Second operation begins from DONE with the operands present then.
REQ-034 SHALL cover: rst_in asserted on the 4th RUN cycle.
- Next edge: busy_out=0, done_out=0, sum_out=0, carry_out=0.
- No done pulse.
- Subsequent start with 0x10+0x20 gives 0x30/0.
REQ-035 SHALL cover a random scoreboard: 1000 random a, b, c operations, including back-to-back starts; each result checked against a+b+c.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and counter sizing for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one bit per RUN cycle
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);
  localparam int CW = cnt_width(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, res_w;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cy_q, cy_d, co_q, co_d, busy_q, busy_d, done_q, done_d;
  logic s, cout, accept, run, last;
  fa_cell u_fa (.a(a_q[0]), .b(b_q[0]), .cin(cy_q), .sum(s), .cout(cout));
  // res_w is the result after this cycle's bit enters from the MSB side
  assign res_w  = {s, res_q};
  assign accept = start_in && (state_q != RUN);
  assign run    = state_q == RUN;
  assign last   = run && (cnt_q == CW'(WIDTH - 1));
  always_comb begin
    state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
    a_d     = accept ? a_in : run ? a_q >> 1 : a_q;
    b_d     = accept ? b_in : run ? b_q >> 1 : b_q;
    cy_d    = accept ? c_in : run ? cout : cy_q;
    cnt_d   = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    res_d   = run ? res_w[WIDTH-1:1] : res_q;
    sum_d   = last ? res_w : sum_q;
    co_d    = last ? cout : co_q;
    busy_d  = state_d == RUN;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign sum_out   = sum_q;
  assign carry_out = co_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: vector table, corner sequences and random scoreboard
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk_in = 1'b0, rst_in, start_in, c_in, busy_out, done_out, carry_out;
  logic [W-1:0] a_in, b_in, sum_out;
  int n_cmp = 0, n_bad = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .a_in(a_in), .b_in(b_in),
    .c_in(c_in), .busy_out(busy_out), .done_out(done_out), .sum_out(sum_out),
    .carry_out(carry_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns the negedge index of the first done pulse, 0 if none within the budget
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      a_in = ~a_in;
      b_in = ~b_in;
      if (done_out) begin
        lat = k;
        break;
      end
      if (busy_out) bcnt++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int bcnt, output int lat);
    @(negedge clk_in);
    start_in = 1'b1;
    a_in = a;
    b_in = b;
    c_in = c;
    wait_done(lat, bcnt);
  endtask

  initial begin
    int bcnt, lat, dones, got;
    logic [W:0] exp_r;
    logic [W-1:0] ra, rb;
    logic rc;
    logic b2b;
    logic [W:0] exp_q[$];
    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    rst_in = 1'b1;
    start_in = 1'b0;
    a_in = '0;
    b_in = '0;
    c_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_carry", carry_out, 0);
    rst_in = 1'b0;

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].c, bcnt, lat);
      chk("vec_busy_cycles", bcnt, 8);
      chk("vec_done_latency", lat, 9);
      chk("vec_sum", sum_out, vt[i].s);
      chk("vec_carry", carry_out, vt[i].co);
      @(negedge clk_in);
      chk("vec_done_once", done_out, 0);
      chk("vec_hold", {carry_out, sum_out}, {vt[i].co, vt[i].s});
    end

    // start held high through RUN: ignored, then accepted from DONE with current operands
    @(negedge clk_in);
    start_in = 1'b1;
    a_in = 8'h01;
    b_in = 8'h01;
    c_in = 1'b0;
    bcnt = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      a_in = 8'hAA;
      b_in = 8'h55;
      if (k == 4) chk("run_hold", {carry_out, sum_out}, 9'h080);
      if (done_out) begin
        lat = k;
        break;
      end
      if (busy_out) bcnt++;
    end
    chk("b2b_first_busy", bcnt, 8);
    chk("b2b_first_lat", lat, 9);
    chk("b2b_first_res", {carry_out, sum_out}, 9'h002);
    @(negedge clk_in);
    chk("b2b_restart_busy", busy_out, 1);
    chk("b2b_restart_done", done_out, 0);
    chk("b2b_restart_hold", {carry_out, sum_out}, 9'h002);
    wait_done(lat, bcnt);
    chk("b2b_second_lat", lat, 8);
    chk("b2b_second_res", {carry_out, sum_out}, 9'h0FF);

    // reset on the 4th RUN cycle aborts with no done pulse
    @(negedge clk_in);
    start_in = 1'b1;
    a_in = 8'h33;
    b_in = 8'h44;
    repeat (4) begin
      @(negedge clk_in);
      start_in = 1'b0;
    end
    chk("pre_abort_busy", busy_out, 1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("abort_busy", busy_out, 0);
    chk("abort_done", done_out, 0);
    chk("abort_sum", sum_out, 0);
    chk("abort_carry", carry_out, 0);
    dones = 0;
    repeat (12) begin
      @(negedge clk_in);
      if (done_out || busy_out) dones++;
    end
    chk("abort_quiet", dones, 0);
    run_op(8'h10, 8'h20, 1'b0, bcnt, lat);
    chk("post_abort_lat", lat, 9);
    chk("post_abort_res", {carry_out, sum_out}, 9'h030);

    // reset wins over a simultaneous start
    @(negedge clk_in);
    rst_in = 1'b1;
    start_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    start_in = 1'b0;
    chk("rst_prio_busy", busy_out, 0);
    @(negedge clk_in);
    chk("rst_prio_idle", busy_out, 0);

    // random scoreboard with back-to-back starts and ignored starts during RUN
    b2b = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk_in);
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      start_in = 1'b1;
      a_in = ra;
      b_in = rb;
      c_in = rc;
      exp_q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      got = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk_in);
        if (done_out) begin
          got = k;
          break;
        end
        start_in = ($urandom_range(0, 3) == 0);
        a_in = W'($urandom);
        b_in = W'($urandom);
        c_in = 1'($urandom);
      end
      exp_r = exp_q.pop_front();
      chk("rand_latency", got, 9);
      chk("rand_result", {carry_out, sum_out}, exp_r);
      b2b = 1'($urandom);
      start_in = 1'b0;
    end
    @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
